gnt_arbiter: RTL

Round-robin arbiter that owns the 4-bit `gnt` vector driven onto the shared `_if` bus. It replaces the free-running grant source with a sequenced one: it samples per-requester `req` lines, issues a registered one-hot grant, holds it for a bounded tenure, and inserts a dead cycle between tenures so no two grants ever overlap. It sits between the requesting agents and the interface; a bench samples `gnt` through the interface clocking blocks.

---
 rtl/gnt_arb_pkg.sv | 18 +
 rtl/gnt_arbiter_rr_pick.sv | 29 ++
 rtl/gnt_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/gnt_arb_pkg.sv
// Shared types and defaults for the round-robin grant arbiter.
package gnt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int N_REQ_DEFAULT    = 4;
  localparam int MAX_HOLD_DEFAULT = 8;

  // Tenure counter width; a single-cycle limit still needs one bit.
  function automatic int cnt_width(input int max_hold);
    return (max_hold > 1) ? $clog2(max_hold) : 1;
  endfunction

endpackage

// File: rtl/gnt_arbiter_rr_pick.sv
// Round-robin selector: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             found,
  output logic [IW-1:0]    idx
);

  logic [N_REQ-1:0] rot;
  logic [IW-1:0]    enc;
  logic [IW:0]      sum;

  // Rotate so ptr sits at bit 0, priority-encode, then rotate the index back.
  always_comb begin
    rot   = N_REQ'({req, req} >> ptr);
    found = |rot;
    enc   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) enc = IW'(k);
    end
    sum = {1'b0, enc} + {1'b0, ptr};
    if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/gnt_arbiter.sv
// Round-robin arbiter with bounded tenure and a dead cycle between grants.
module gnt_arbiter
  import gnt_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     hold_expired
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = cnt_width(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] ID_LAST   = IW'(N_REQ - 1);

  arb_state_t       state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [HW-1:0]    hold_cnt, hold_cnt_n;
  logic [N_REQ-1:0] gnt_n;
  logic [IW-1:0]    gnt_id_n;
  logic             busy_n;
  logic             hexp_n;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             at_limit;

  rr_pick #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_pick (
    .req  (req),
    .ptr  (ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  assign at_limit = (hold_cnt == HOLD_LAST);

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    hold_cnt_n = hold_cnt;
    gnt_n      = gnt;
    gnt_id_n   = gnt_id;
    busy_n     = busy;
    hexp_n     = 1'b0;
    case (state)
      IDLE: begin
        if (en && pick_found) begin
          gnt_n      = N_REQ'(1) << pick_idx;
          gnt_id_n   = pick_idx;
          busy_n     = 1'b1;
          hold_cnt_n = '0;
          state_n    = GRANT;
        end
      end
      GRANT: begin
        // A limit hit wins over a simultaneous request drop.
        if (at_limit || !req[gnt_id]) begin
          gnt_n   = '0;
          busy_n  = 1'b0;
          hexp_n  = at_limit;
          ptr_n   = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;
          state_n = RELEASE;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, pointer, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      hold_cnt     <= '0;
      gnt          <= '0;
      gnt_id       <= '0;
      busy         <= 1'b0;
      hold_expired <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      hold_cnt     <= hold_cnt_n;
      gnt          <= gnt_n;
      gnt_id       <= gnt_id_n;
      busy         <= busy_n;
      hold_expired <= hexp_n;
    end
  end

endmodule
